motor_step_responder: RTL



---
 rtl/motor_step_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/motor_step_responder.sv
// Motor-side responder for the CPU motor handshake.
// Accepts a move request, clamps and latches the target position, and
// issues step/dir pulses until the absolute position reaches the target.
// It then raises motor_ready and holds it until the request is withdrawn.
module motor_step_responder #(
    parameter int POS_W       = 16,
    parameter int STEP_HI     = 50,
    parameter int STEP_PERIOD = 500,
    parameter int POS_MIN     = -1600,
    parameter int POS_MAX     = 1600
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             motor_driver,
    input  logic [POS_W-1:0] target,
    output logic             motor_ready,
    output logic             step,
    output logic             dir,
    output logic             motor_en,
    output logic [POS_W-1:0] position,
    output logic             busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] STEP_H = 3'd2;
    localparam logic [2:0] STEP_L = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam int CNT_W = (STEP_PERIOD > 2) ? $clog2(STEP_PERIOD) : 1;
    localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(STEP_HI - 1);
    localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(STEP_PERIOD - STEP_HI - 1);

    localparam logic signed [POS_W-1:0] MIN_V = POS_W'(POS_MIN);
    localparam logic signed [POS_W-1:0] MAX_V = POS_W'(POS_MAX);

    logic [2:0]              state;
    logic [2:0]              next_state;
    logic [CNT_W-1:0]        cnt;
    logic [POS_W:0]          remaining;
    logic signed [POS_W-1:0] tgt_q;
    logic signed [POS_W-1:0] tgt_clamped;
    logic signed [POS_W:0]   delta;
    logic [POS_W:0]          delta_abs;
    logic [POS_W-1:0]        pos_inc;

    // Saturate the requested target into the legal travel range
    always_comb begin
        tgt_clamped = $signed(target);
        if ($signed(target) < MIN_V) begin
            tgt_clamped = MIN_V;
        end else if ($signed(target) > MAX_V) begin
            tgt_clamped = MAX_V;
        end
    end

    // Distance to travel, one bit wider so the subtraction cannot overflow
    always_comb begin
        delta     = $signed({tgt_q[POS_W-1], tgt_q}) - $signed({position[POS_W-1], position});
        delta_abs = delta[POS_W] ? $unsigned(-delta) : $unsigned(delta);
        pos_inc   = dir ? POS_W'(1) : {POS_W{1'b1}};
    end

    // Next-state decode for the move sequencer
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (motor_driver) next_state = LOAD;
            LOAD:    next_state = (delta == '0) ? DONE : STEP_H;
            STEP_H:  if (cnt == HI_LAST) next_state = STEP_L;
            STEP_L:  if (cnt == LO_LAST) next_state = (remaining == (POS_W+1)'(1)) ? DONE : STEP_H;
            DONE:    if (!motor_driver) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, datapath and registered outputs; ready lags DONE by one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            remaining   <= '0;
            tgt_q       <= '0;
            position    <= '0;
            dir         <= 1'b0;
            step        <= 1'b0;
            motor_ready <= 1'b0;
            motor_en    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= next_state;
            motor_ready <= (state == DONE);
            step        <= (next_state == STEP_H);
            motor_en    <= (next_state != IDLE);
            busy        <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    if (motor_driver) begin
                        tgt_q <= tgt_clamped;
                    end
                end
                LOAD: begin
                    dir       <= !delta[POS_W] && (delta != '0);
                    remaining <= delta_abs;
                    cnt       <= '0;
                end
                STEP_H: begin
                    if (cnt == HI_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STEP_L: begin
                    if (cnt == LO_LAST) begin
                        cnt       <= '0;
                        position  <= position + pos_inc;
                        remaining <= remaining - (POS_W+1)'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
